// File: rtl/ex_hazard_ctrl_pkg.sv
// Shared defines and types for the EX hazard controller: datapath width,
// the hard-wired zero register index and the controller FSM encodings.
`ifndef XLEN
`define XLEN 32
`endif

package ex_hazard_ctrl_pkg;
  localparam int XLEN = `XLEN;

  // x0 never carries a real dependency, so it is excluded from hazards
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LU   = 2'd1,
    ST_TRAP = 2'd2
  } state_e;
endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle. The master is the pipeline side
// (drives stage status, consumes stall/flush/redirect); the slave is the
// controller.
interface ex_hazard_ctrl_if #(parameter int CNT_W = 32);
  import ex_hazard_ctrl_pkg::*;

  logic             ID_valid_i;
  logic             ID_rs1_ren_i;
  logic             ID_rs2_ren_i;
  logic [4:0]       ID_rs1_idx_i;
  logic [4:0]       ID_rs2_idx_i;
  logic             EX_valid_i;
  logic             EX_op_load_i;
  logic             EX_rd_wen_i;
  logic [4:0]       EX_rd_idx_i;
  logic             EX_mispredict_i;
  logic [XLEN-1:0]  EX_redirect_pc_i;
  logic             WB_trap_i;
  logic             WB_mret_i;
  logic [XLEN-1:0]  trap_vec_i;
  logic [XLEN-1:0]  mepc_i;
  logic             MEM_ready_i;

  logic             stall_id_o;
  logic             bubble_ex_o;
  logic             if_flush_o;
  logic             id_flush_o;
  logic             ex_flush_o;
  logic             redirect_valid_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] lu_stall_cnt_o;

  modport master (
    output ID_valid_i, ID_rs1_ren_i, ID_rs2_ren_i, ID_rs1_idx_i, ID_rs2_idx_i,
    output EX_valid_i, EX_op_load_i, EX_rd_wen_i, EX_rd_idx_i,
    output EX_mispredict_i, EX_redirect_pc_i,
    output WB_trap_i, WB_mret_i, trap_vec_i, mepc_i, MEM_ready_i,
    input  stall_id_o, bubble_ex_o, if_flush_o, id_flush_o, ex_flush_o,
    input  redirect_valid_o, redirect_pc_o, state_o, lu_stall_cnt_o
  );

  modport slave (
    input  ID_valid_i, ID_rs1_ren_i, ID_rs2_ren_i, ID_rs1_idx_i, ID_rs2_idx_i,
    input  EX_valid_i, EX_op_load_i, EX_rd_wen_i, EX_rd_idx_i,
    input  EX_mispredict_i, EX_redirect_pc_i,
    input  WB_trap_i, WB_mret_i, trap_vec_i, mepc_i, MEM_ready_i,
    output stall_id_o, bubble_ex_o, if_flush_o, id_flush_o, ex_flush_o,
    output redirect_valid_o, redirect_pc_o, state_o, lu_stall_cnt_o
  );
endinterface

// File: rtl/ex_hazard_ctrl_lu_hazard_det.sv
// Load-use dependency detector: a valid load in EX writing a non-zero
// register that the valid ID instruction reads on either source port.
module lu_hazard_det
  import ex_hazard_ctrl_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_load,
  input  logic       ex_rd_wen,
  input  logic [4:0] ex_rd_idx,
  input  logic       id_valid,
  input  logic       rs1_ren,
  input  logic [4:0] rs1_idx,
  input  logic       rs2_ren,
  input  logic [4:0] rs2_idx,
  output logic       hazard
);
  logic producer, rs1_hit, rs2_hit;

  assign producer = ex_valid & ex_load & ex_rd_wen & (ex_rd_idx != REG_X0);
  assign rs1_hit  = rs1_ren & (rs1_idx == ex_rd_idx);
  assign rs2_hit  = rs2_ren & (rs2_idx == ex_rd_idx);
  assign hazard   = producer & id_valid & (rs1_hit | rs2_hit);
endmodule

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: 2-cycle load-use stall, mispredict flush and
// trap/mret flush with a registered one-cycle fetch redirect. A low
// MEM_ready freezes all state while the flush outputs stay live.
module ex_hazard_ctrl
  import ex_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_hazard_ctrl_if.slave bus
);
  state_e            state, state_nxt;
  logic              hazard, trap, in_trap, ready;
  logic              stall, bubble, if_fl, id_fl, ex_fl;
  logic              rdr_valid;
  logic [XLEN-1:0]   rdr_pc;
  logic [CNT_W-1:0]  cnt;

  lu_hazard_det u_det (
    .ex_valid  (bus.EX_valid_i),
    .ex_load   (bus.EX_op_load_i),
    .ex_rd_wen (bus.EX_rd_wen_i),
    .ex_rd_idx (bus.EX_rd_idx_i),
    .id_valid  (bus.ID_valid_i),
    .rs1_ren   (bus.ID_rs1_ren_i),
    .rs1_idx   (bus.ID_rs1_idx_i),
    .rs2_ren   (bus.ID_rs2_ren_i),
    .rs2_idx   (bus.ID_rs2_idx_i),
    .hazard    (hazard)
  );

  assign ready   = bus.MEM_ready_i;
  assign trap    = bus.WB_trap_i | bus.WB_mret_i;
  // TRAP state keeps every stage flushed for its single cycle
  assign in_trap = trap | (state == ST_TRAP);

  // state register; frozen while downstream is not ready
  always_ff @(posedge clk) begin
    if (rst)        state <= ST_RUN;
    else if (ready) state <= state_nxt;
  end

  // next state: trap > mispredict > load-use; LU and TRAP last one cycle
  always_comb begin
    state_nxt = ST_RUN;
    if (trap)                               state_nxt = ST_TRAP;
    else if (state == ST_TRAP)              state_nxt = ST_RUN;
    else if (bus.EX_mispredict_i)           state_nxt = ST_RUN;
    else if ((state == ST_RUN) && hazard)   state_nxt = ST_LU;
  end

  // stall/bubble/flush outputs, all forced low during reset
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    if_fl  = 1'b0;
    id_fl  = 1'b0;
    ex_fl  = 1'b0;
    if (!rst) begin
      if (in_trap) begin
        if_fl = 1'b1;
        id_fl = 1'b1;
        ex_fl = 1'b1;
      end else if (bus.EX_mispredict_i) begin
        if_fl = 1'b1;
        id_fl = 1'b1;
      end else if ((state == ST_LU) || ((state == ST_RUN) && hazard)) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
      if (!ready) stall = 1'b1;
    end
  end

  // redirect register: one-cycle pulse, PC zeroed when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rdr_valid <= 1'b0;
      rdr_pc    <= '0;
    end else if (ready) begin
      if (trap) begin
        rdr_valid <= 1'b1;
        rdr_pc    <= bus.WB_trap_i ? bus.trap_vec_i : bus.mepc_i;
      end else if ((state != ST_TRAP) && bus.EX_mispredict_i) begin
        rdr_valid <= 1'b1;
        rdr_pc    <= bus.EX_redirect_pc_i;
      end else begin
        rdr_valid <= 1'b0;
        rdr_pc    <= '0;
      end
    end
  end

  // saturating count of cycles that actually inserted a bubble
  always_ff @(posedge clk) begin
    if (rst)                                 cnt <= '0;
    else if (ready && bubble && (cnt != '1)) cnt <= cnt + CNT_W'(1);
  end

  assign bus.stall_id_o       = stall;
  assign bus.bubble_ex_o      = bubble;
  assign bus.if_flush_o       = if_fl;
  assign bus.id_flush_o       = id_fl;
  assign bus.ex_flush_o       = ex_fl;
  assign bus.redirect_valid_o = rdr_valid;
  assign bus.redirect_pc_o    = rdr_pc;
  assign bus.state_o          = state;
  assign bus.lu_stall_cnt_o   = cnt;
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboard bench for ex_hazard_ctrl: the driver applies one directed
// vector per cycle and queues the hand-computed response; the monitor pops
// and compares at each falling edge.
module tb_ex_hazard_ctrl;
  localparam int CNT_W = 4;

  typedef struct {
    logic        rst;
    logic        id_valid, rs1_ren, rs2_ren;
    logic [4:0]  rs1, rs2;
    logic        ex_valid, ex_load, ex_wen;
    logic [4:0]  ex_rd;
    logic        mispredict;
    logic [31:0] ex_pc;
    logic        wb_trap, wb_mret;
    logic [31:0] trap_vec, mepc;
    logic        ready;
  } vec_t;

  typedef struct {
    string       name;
    logic        stall, bubble;
    logic [2:0]  fl;
    logic        rv;
    logic [31:0] pc;
    logic [1:0]  st;
    logic [3:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  ex_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  ex_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t nop();
    vec_t v;
    v = '{rst: 1'b0, id_valid: 1'b0, rs1_ren: 1'b0, rs2_ren: 1'b0, rs1: 5'd0,
          rs2: 5'd0, ex_valid: 1'b0, ex_load: 1'b0, ex_wen: 1'b0, ex_rd: 5'd0,
          mispredict: 1'b0, ex_pc: 32'h0, wb_trap: 1'b0, wb_mret: 1'b0,
          trap_vec: 32'h0, mepc: 32'h0, ready: 1'b1};
    return v;
  endfunction

  // EX: lw x<rd>; ID: add x6, x<rd>, x1
  function automatic vec_t hz(input logic [4:0] rd);
    vec_t v;
    v = nop();
    v.ex_valid = 1'b1; v.ex_load = 1'b1; v.ex_wen = 1'b1; v.ex_rd = rd;
    v.id_valid = 1'b1; v.rs1_ren = 1'b1; v.rs1 = rd;
    v.rs2_ren  = 1'b1; v.rs2 = 5'd1;
    return v;
  endfunction

  function automatic exp_t ex(input string n, input logic s, input logic b,
                              input logic [2:0] fl, input logic rv,
                              input logic [31:0] pc, input logic [1:0] st,
                              input int cnt);
    exp_t e;
    e = '{name: n, stall: s, bubble: b, fl: fl, rv: rv, pc: pc, st: st,
          cnt: cnt[3:0]};
    return e;
  endfunction

  function automatic int sat(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic step(input vec_t v, input exp_t e, input bit chk);
    @(posedge clk);
    #1;
    rst                  = v.rst;
    bus.ID_valid_i       = v.id_valid;
    bus.ID_rs1_ren_i     = v.rs1_ren;
    bus.ID_rs2_ren_i     = v.rs2_ren;
    bus.ID_rs1_idx_i     = v.rs1;
    bus.ID_rs2_idx_i     = v.rs2;
    bus.EX_valid_i       = v.ex_valid;
    bus.EX_op_load_i     = v.ex_load;
    bus.EX_rd_wen_i      = v.ex_wen;
    bus.EX_rd_idx_i      = v.ex_rd;
    bus.EX_mispredict_i  = v.mispredict;
    bus.EX_redirect_pc_i = v.ex_pc;
    bus.WB_trap_i        = v.wb_trap;
    bus.WB_mret_i        = v.wb_mret;
    bus.trap_vec_i       = v.trap_vec;
    bus.mepc_i           = v.mepc;
    bus.MEM_ready_i      = v.ready;
    if (chk) exp_q.push_back(e);
  endtask

  // monitor: every cycle the controller presents a full response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.stall_id_o !== e.stall || bus.bubble_ex_o !== e.bubble ||
            {bus.if_flush_o, bus.id_flush_o, bus.ex_flush_o} !== e.fl ||
            bus.redirect_valid_o !== e.rv || bus.redirect_pc_o !== e.pc ||
            bus.state_o !== e.st || bus.lu_stall_cnt_o !== e.cnt) begin
          failures++;
          $display("FAIL %s: got stall=%b bubble=%b flush=%b rv=%b pc=%h st=%0d cnt=%0d, want stall=%b bubble=%b flush=%b rv=%b pc=%h st=%0d cnt=%0d",
                   e.name, bus.stall_id_o, bus.bubble_ex_o,
                   {bus.if_flush_o, bus.id_flush_o, bus.ex_flush_o},
                   bus.redirect_valid_o, bus.redirect_pc_o, bus.state_o,
                   bus.lu_stall_cnt_o, e.stall, e.bubble, e.fl, e.rv, e.pc,
                   e.st, e.cnt);
        end
      end
    end
  end

  initial begin
    vec_t v;
    vec_t n;
    n = nop();
    rst = 1'b1;
    step(v_rst(nop()), ex("r1", 0, 0, 3'b000, 0, 0, 0, 0), 1'b0);
    // reset with hazard and trap present: combinational outputs stay low
    v = hz(5'd5); v.rst = 1'b1; v.wb_trap = 1'b1;
    step(v, ex("reset", 0, 0, 3'b000, 0, 0, 0, 0), 1'b1);

    // basic load-use: RUN, LU, RUN
    step(hz(5'd5), ex("lu_run", 1, 1, 3'b000, 0, 0, 0, 0), 1'b1);
    step(n,        ex("lu_lu",  1, 1, 3'b000, 0, 0, 1, 1), 1'b1);
    v = n; v.ex_valid = 1'b1; v.ex_wen = 1'b1; v.ex_rd = 5'd6;
    step(v,        ex("lu_done", 0, 0, 3'b000, 0, 0, 0, 2), 1'b1);
    // x0 destination never stalls
    v = hz(5'd0); v.rs2 = 5'd0;
    step(v,        ex("x0", 0, 0, 3'b000, 0, 0, 0, 2), 1'b1);
    // rs2 match only
    v = hz(5'd7); v.rs1 = 5'd3; v.rs2 = 5'd7;
    step(v,        ex("rs2_run", 1, 1, 3'b000, 0, 0, 0, 2), 1'b1);
    step(n,        ex("rs2_lu",  1, 1, 3'b000, 0, 0, 1, 3), 1'b1);
    // index matches but port not read
    v = hz(5'd9); v.rs1 = 5'd2; v.rs2 = 5'd9; v.rs2_ren = 1'b0;
    step(v,        ex("no_ren", 0, 0, 3'b000, 0, 0, 0, 4), 1'b1);

    // mispredict beats a pending hazard
    v = hz(5'd5); v.mispredict = 1'b1; v.ex_pc = 32'h8000_0040;
    step(v,        ex("mp", 0, 0, 3'b110, 0, 0, 0, 4), 1'b1);
    step(n,        ex("mp_rdr", 0, 0, 3'b000, 1, 32'h8000_0040, 0, 4), 1'b1);
    step(n,        ex("mp_pulse", 0, 0, 3'b000, 0, 0, 0, 4), 1'b1);

    // trap during LU, with mret also set: trap vector wins
    step(hz(5'd5), ex("tr_hz", 1, 1, 3'b000, 0, 0, 0, 4), 1'b1);
    v = n; v.wb_trap = 1'b1; v.wb_mret = 1'b1;
    v.trap_vec = 32'h8000_0100; v.mepc = 32'h1234_5678;
    step(v,        ex("tr_in_lu", 0, 0, 3'b111, 0, 0, 1, 5), 1'b1);
    step(n,        ex("tr_state", 0, 0, 3'b111, 1, 32'h8000_0100, 2, 5), 1'b1);
    step(n,        ex("tr_run", 0, 0, 3'b000, 0, 0, 0, 5), 1'b1);

    // mispredict kills an active LU
    step(hz(5'd5), ex("mplu_hz", 1, 1, 3'b000, 0, 0, 0, 5), 1'b1);
    v = n; v.mispredict = 1'b1; v.ex_pc = 32'h8000_0200;
    step(v,        ex("mplu_lu", 0, 0, 3'b110, 0, 0, 1, 6), 1'b1);
    step(n,        ex("mplu_rdr", 0, 0, 3'b000, 1, 32'h8000_0200, 0, 6), 1'b1);

    // mret held by MEM_ready low
    v = n; v.wb_mret = 1'b1; v.mepc = 32'h8000_0008; v.trap_vec = 32'h8000_0100;
    v.ready = 1'b0;
    step(v,        ex("mret_hold0", 1, 0, 3'b111, 0, 0, 0, 6), 1'b1);
    step(v,        ex("mret_hold1", 1, 0, 3'b111, 0, 0, 0, 6), 1'b1);
    v.ready = 1'b1;
    step(v,        ex("mret_go", 0, 0, 3'b111, 0, 0, 0, 6), 1'b1);
    step(n,        ex("mret_trap", 0, 0, 3'b111, 1, 32'h8000_0008, 2, 6), 1'b1);
    step(n,        ex("mret_run", 0, 0, 3'b000, 0, 0, 0, 6), 1'b1);

    // LU frozen by MEM_ready low: bubble without ready is not counted
    step(hz(5'd5), ex("frz_hz", 1, 1, 3'b000, 0, 0, 0, 6), 1'b1);
    v = n; v.ready = 1'b0;
    step(v,        ex("frz_lu0", 1, 1, 3'b000, 0, 0, 1, 7), 1'b1);
    step(n,        ex("frz_lu1", 1, 1, 3'b000, 0, 0, 1, 7), 1'b1);
    step(n,        ex("frz_run", 0, 0, 3'b000, 0, 0, 0, 8), 1'b1);

    // trap while in TRAP re-enters TRAP
    v = n; v.wb_trap = 1'b1; v.trap_vec = 32'h8000_0300;
    step(v,        ex("tt_0", 0, 0, 3'b111, 0, 0, 0, 8), 1'b1);
    v.trap_vec = 32'h8000_0400;
    step(v,        ex("tt_1", 0, 0, 3'b111, 1, 32'h8000_0300, 2, 8), 1'b1);
    step(n,        ex("tt_2", 0, 0, 3'b111, 1, 32'h8000_0400, 2, 8), 1'b1);
    step(n,        ex("tt_run", 0, 0, 3'b000, 0, 0, 0, 8), 1'b1);

    // reset mid-LU and mid-TRAP
    step(hz(5'd5), ex("rlu_hz", 1, 1, 3'b000, 0, 0, 0, 8), 1'b1);
    v = n; v.rst = 1'b1;
    step(v,        ex("rlu_rst", 0, 0, 3'b000, 0, 0, 1, 9), 1'b1);
    step(n,        ex("rlu_after", 0, 0, 3'b000, 0, 0, 0, 0), 1'b1);
    v = n; v.wb_trap = 1'b1; v.trap_vec = 32'h8000_0500;
    step(v,        ex("rtr_trap", 0, 0, 3'b111, 0, 0, 0, 0), 1'b1);
    v = n; v.rst = 1'b1;
    step(v,        ex("rtr_rst", 0, 0, 3'b000, 1, 32'h8000_0500, 2, 0), 1'b1);
    step(n,        ex("rtr_after", 0, 0, 3'b000, 0, 0, 0, 0), 1'b1);

    // 8 back-to-back load-use pairs saturate the 4-bit counter
    for (int i = 0; i < 8; i++) begin
      step(hz(5'd5), ex($sformatf("sat_h%0d", i), 1, 1, 3'b000, 0, 0, 0, sat(2*i)), 1'b1);
      step(n,        ex($sformatf("sat_l%0d", i), 1, 1, 3'b000, 0, 0, 1, sat(2*i+1)), 1'b1);
    end
    step(n,        ex("sat_end", 0, 0, 3'b000, 0, 0, 0, 15), 1'b1);
    v = n; v.rst = 1'b1;
    step(v,        ex("sat_rst", 0, 0, 3'b000, 0, 0, 0, 15), 1'b1);
    step(n,        ex("sat_clr", 0, 0, 3'b000, 0, 0, 0, 0), 1'b1);

    // bounded drain of the scoreboard
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d responses left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic vec_t v_rst(input vec_t v);
    vec_t r;
    r = v;
    r.rst = 1'b1;
    return r;
  endfunction
endmodule
